arcade_input_mapper: RTL and testbench

Parametrised input front-end for arcade cores: merges PS/2 keyboard events and per-player joystick words into registered per-player control outputs. Adds display-rotation remap (CW/CCW), per-player autofire, and a debounced fixed-width coin pulse generator with optional coin-on-start. Sits between hps_io and the game core, replacing per-core hand-written key decode.

---
 rtl/arcade_input_mapper.sv | 138 +++++++++++++
 tb/tb_arcade_input_mapper.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: merges PS/2 keys and joystick words into registered per-player controls
// with rotation remap, shared-phase autofire and debounced fixed-width coin pulses.
module arcade_input_mapper #(
    parameter int          PLAYERS    = 2,
    parameter logic [15:0] COIN_PULSE = 16'd4096,
    parameter logic [15:0] COIN_GAP   = 16'd4096,
    parameter logic [19:0] AF_DIV     = 20'd300000
) (
    input  logic                  clk_sys,
    input  logic                  reset_n,
    input  logic [10:0]           ps2_key,
    input  logic [16*PLAYERS-1:0] joy,
    input  logic                  rotate,
    input  logic                  rot_ccw,
    input  logic                  coin_on_start,
    input  logic [PLAYERS-1:0]    af_en,
    output logic [PLAYERS-1:0]    up,
    output logic [PLAYERS-1:0]    down,
    output logic [PLAYERS-1:0]    left,
    output logic [PLAYERS-1:0]    right,
    output logic [PLAYERS-1:0]    fire1,
    output logic [PLAYERS-1:0]    fire2,
    output logic [PLAYERS-1:0]    start,
    output logic [PLAYERS-1:0]    coin
);
    typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;

    logic                 init, old_tog, phase, pr, ext;
    logic [8:0]           k1;
    logic [7:0]           k2;
    logic [19:0]          af_cnt;
    logic [7:0]           raw [PLAYERS];
    logic [PLAYERS-1:0]   trig, trig_q;
    logic [8*PLAYERS-1:0] joy_hi;
    logic                 unused_joy;
    coin_state_t          cst [PLAYERS];
    logic [15:0]          ctim [PLAYERS];

    assign pr = ps2_key[9];
    assign ext = ps2_key[8];
    assign unused_joy = ^joy_hi;

    // Key latches follow the joystick bit order; k1[8] is the second P1 fire key.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            init <= 1'b1;
            old_tog <= 1'b0;
            k1 <= '0;
            k2 <= '0;
        end else if (init) begin
            init <= 1'b0;
            old_tog <= ps2_key[10];
        end else if (ps2_key[10] != old_tog) begin
            old_tog <= ps2_key[10];
            case (ps2_key[7:0])
                8'h75: k1[3] <= pr;
                8'h72: k1[2] <= pr;
                8'h6B: k1[1] <= pr;
                8'h74: k1[0] <= pr;
                8'h14: if (!ext) k1[4] <= pr;
                8'h29: if (!ext) k1[8] <= pr;
                8'h11: if (!ext) k1[5] <= pr;
                8'h16: if (!ext) k1[6] <= pr;
                8'h2E: if (!ext) k1[7] <= pr;
                8'h2D: if (!ext) k2[3] <= pr;
                8'h2B: if (!ext) k2[2] <= pr;
                8'h23: if (!ext) k2[1] <= pr;
                8'h34: if (!ext) k2[0] <= pr;
                8'h1C: if (!ext) k2[4] <= pr;
                8'h1B: if (!ext) k2[5] <= pr;
                8'h1E: if (!ext) k2[6] <= pr;
                8'h36: if (!ext) k2[7] <= pr;
                default: ;
            endcase
        end
    end

    always_comb begin
        for (int p = 0; p < PLAYERS; p++) begin
            raw[p] = joy[16*p +: 8] | (p == 0 ? {k1[7:5], k1[4] | k1[8], k1[3:0]} : p == 1 ? k2 : 8'd0);
            trig[p] = raw[p][7] | (coin_on_start & raw[p][6]);
            joy_hi[8*p +: 8] = joy[16*p+8 +: 8];
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            af_cnt <= '0;
            phase <= 1'b0;
        end else begin
            af_cnt <= af_cnt == AF_DIV - 20'd1 ? 20'd0 : af_cnt + 20'd1;
            phase <= af_cnt == AF_DIV - 20'd1 ? ~phase : phase;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            {up, down, left, right, fire1, fire2, start, coin} <= '0;
            trig_q <= '0;
            for (int p = 0; p < PLAYERS; p++) begin
                cst[p] <= IDLE;
                ctim[p] <= '0;
            end
        end else begin
            trig_q <= trig;
            for (int p = 0; p < PLAYERS; p++) begin
                up[p] <= rotate ? (rot_ccw ? raw[p][0] : raw[p][1]) : raw[p][3];
                down[p] <= rotate ? (rot_ccw ? raw[p][1] : raw[p][0]) : raw[p][2];
                left[p] <= rotate ? (rot_ccw ? raw[p][3] : raw[p][2]) : raw[p][1];
                right[p] <= rotate ? (rot_ccw ? raw[p][2] : raw[p][3]) : raw[p][0];
                fire1[p] <= raw[p][4] & (af_en[p] ? phase : 1'b1);
                fire2[p] <= raw[p][5];
                start[p] <= raw[p][6];
                case (cst[p])
                    IDLE: if (trig[p] && !trig_q[p]) begin
                        cst[p] <= PULSE;
                        ctim[p] <= '0;
                        coin[p] <= 1'b1;
                    end
                    PULSE: if (ctim[p] == COIN_PULSE - 16'd1) begin
                        cst[p] <= GAP;
                        ctim[p] <= '0;
                        coin[p] <= 1'b0;
                    end else begin
                        ctim[p] <= ctim[p] + 16'd1;
                    end
                    // Gap timer saturates; a held trigger parks here until released.
                    GAP: if (ctim[p] >= COIN_GAP - 16'd1) begin
                        if (!trig[p]) cst[p] <= IDLE;
                    end else begin
                        ctim[p] <= ctim[p] + 16'd1;
                    end
                    default: cst[p] <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: directed vectors; expectations are queued per cycle and
// checked by an independent negedge monitor against the packed DUT outputs.
module tb_arcade_input_mapper;
    localparam int UP = 0, DN = 4, LF = 8, RT = 12, F1 = 16, F2 = 20, ST = 24, CN = 28;
    localparam logic [31:0] ALL = 32'hFFFF_FFFF;

    typedef struct {
        int          cyc;
        string       name;
        logic [31:0] mask;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0, reset_n;
    logic [10:0] ps2_key;
    logic [63:0] joy;
    logic        rotate, rot_ccw, coin_on_start, tog;
    logic [3:0]  af_en, up, down, left, right, fire1, fire2, start, coin;
    logic [31:0] obs;
    exp_t        q[$];
    int          cyc = 0, n_checks = 0, n_fail = 0, r = 0, s = 0, guard = 0;

    arcade_input_mapper #(
        .PLAYERS(4), .COIN_PULSE(16'd4), .COIN_GAP(16'd3), .AF_DIV(20'd5)
    ) dut (
        .clk_sys(clk), .reset_n(reset_n), .ps2_key(ps2_key), .joy(joy),
        .rotate(rotate), .rot_ccw(rot_ccw), .coin_on_start(coin_on_start), .af_en(af_en),
        .up(up), .down(down), .left(left), .right(right),
        .fire1(fire1), .fire2(fire2), .start(start), .coin(coin)
    );

    assign obs = {coin, start, fire2, fire1, right, left, down, up};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc <= cyc) begin
                n_checks++;
                if (q[i].cyc < cyc || ((obs ^ q[i].val) & q[i].mask) !== 32'd0) begin
                    n_fail++;
                    $display("FAIL %s at cycle %0d (due %0d): got %h, want %h (mask %h)",
                             q[i].name, cyc, q[i].cyc, obs & q[i].mask, q[i].val, q[i].mask);
                end
                q.delete(i);
            end
        end
    end

    task automatic exp_at(input int c, input string n, input logic [31:0] m, input logic [31:0] v);
        q.push_back('{cyc: c, name: n, mask: m, val: v});
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key(input logic p, input logic e, input logic [7:0] code);
        tog = ~tog;
        ps2_key = {tog, p, e, code};
    endtask

    initial begin
        reset_n = 1'b0;
        tog = 1'b1;
        ps2_key = 11'h675;
        joy = '0;
        rotate = 1'b0;
        rot_ccw = 1'b0;
        coin_on_start = 1'b0;
        af_en = '0;
        tick(3);
        exp_at(cyc, "reset", ALL, 32'd0);
        reset_n = 1'b1;
        r = cyc;
        for (int i = 1; i <= 5; i++) exp_at(cyc + i, "no_spurious", ALL, 32'd0);
        tick(5);
        key(1'b1, 1'b0, 8'h75);
        exp_at(cyc + 1, "key_latency", ALL, 32'd0);
        exp_at(cyc + 2, "key_up0_only", ALL, 32'd1 << UP);
        tick(3);
        key(1'b0, 1'b0, 8'h75);
        exp_at(cyc + 2, "key_release", ALL, 32'd0);
        tick(3);

        rotate = 1'b1;
        joy[1] = 1'b1;
        exp_at(cyc + 1, "cw_left", ALL, 32'd1 << UP);
        tick(1);
        rot_ccw = 1'b1;
        exp_at(cyc + 1, "ccw_left", ALL, 32'd1 << DN);
        tick(1);
        rotate = 1'b0;
        exp_at(cyc + 1, "pass_left", ALL, 32'd1 << LF);
        tick(1);
        joy = '0;
        joy[3] = 1'b1;
        rotate = 1'b1;
        rot_ccw = 1'b0;
        exp_at(cyc + 1, "cw_up", ALL, 32'd1 << RT);
        tick(1);
        rot_ccw = 1'b1;
        exp_at(cyc + 1, "ccw_up", ALL, 32'd1 << LF);
        tick(1);
        rotate = 1'b0;
        rot_ccw = 1'b0;
        joy = '0;
        joy[51] = 1'b1;
        exp_at(cyc + 1, "p4_up", ALL, 32'd1 << (UP + 3));
        tick(1);
        joy = '0;
        exp_at(cyc + 1, "idle", ALL, 32'd0);
        tick(2);

        key(1'b1, 1'b0, 8'h2E);
        s = cyc;
        for (int i = 1; i <= 50; i++)
            exp_at(s + i, "coin_hold", 32'hF000_0000, (i >= 2 && i <= 5) ? 32'd1 << CN : 32'd0);
        tick(50);
        key(1'b0, 1'b0, 8'h2E);
        tick(3);
        key(1'b1, 1'b0, 8'h2E);
        s = cyc;
        for (int i = 1; i <= 12; i++)
            exp_at(s + i, "coin_repress", 32'hF000_0000, (i >= 2 && i <= 5) ? 32'd1 << CN : 32'd0);
        tick(12);
        key(1'b0, 1'b0, 8'h2E);
        tick(6);

        key(1'b0, 1'b0, 8'h1C);
        for (int i = 1; i <= 3; i++) exp_at(cyc + i, "release_unpressed", ALL, 32'd0);
        tick(3);
        key(1'b1, 1'b1, 8'h14);
        exp_at(cyc + 2, "ext_fire_ignored", ALL, 32'd0);
        tick(3);
        key(1'b1, 1'b0, 8'h29);
        exp_at(cyc + 2, "p1_fire_alt", ALL, 32'd1 << F1);
        tick(3);
        key(1'b1, 1'b0, 8'h1C);
        exp_at(cyc + 2, "p2_fire_key", ALL, 32'd3 << F1);
        tick(3);
        key(1'b0, 1'b0, 8'h29);
        tick(1);
        key(1'b0, 1'b0, 8'h1C);
        exp_at(cyc + 2, "fire_keys_released", ALL, 32'd0);
        tick(3);

        coin_on_start = 1'b1;
        joy[22] = 1'b1;
        s = cyc;
        for (int i = 1; i <= 15; i++)
            exp_at(s + i, "coin_on_start", 32'hFF00_0000,
                   (32'd1 << (ST + 1)) | (i <= 4 ? 32'd1 << (CN + 1) : 32'd0));
        tick(15);
        joy = '0;
        coin_on_start = 1'b0;
        tick(6);

        af_en = 4'b0001;
        joy[4] = 1'b1;
        joy[5] = 1'b1;
        joy[20] = 1'b1;
        s = cyc;
        for (int i = 1; i <= 20; i++)
            exp_at(s + i, "autofire", 32'h0013_0000,
                   32'h0012_0000 | ((((s + i - r - 1) / 5) % 2) == 1 ? 32'h0001_0000 : 32'h0));
        tick(20);
        joy = '0;
        af_en = '0;
        tick(2);

        joy[7] = 1'b1;
        s = cyc;
        exp_at(s + 1, "coin_pre_reset", 32'hF000_0000, 32'd1 << CN);
        tick(2);
        reset_n = 1'b0;
        exp_at(cyc, "reset_async", ALL, 32'd0);
        joy = '0;
        key(1'b1, 1'b0, 8'h75);
        tick(3);
        reset_n = 1'b1;
        for (int i = 1; i <= 4; i++) exp_at(cyc + i, "init_rearmed", ALL, 32'd0);
        tick(4);
        key(1'b1, 1'b0, 8'h75);
        exp_at(cyc + 2, "post_reset_key", ALL, 32'd1 << UP);
        tick(3);

        while (q.size() != 0 && guard < 100) begin
            tick(1);
            guard++;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations pending, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
